// File: rtl/gtfwizard_mac_example_reset_ctrl.sv
// Reset sequencer for one GTF channel: PLL, TX datapath, then RX datapath resets with lock waits.
// Optional timeout event counter output enabled by defining GTF_RESET_CTRL_TIMEOUT_CNT_EN.
module gtfwizard_mac_example_reset_ctrl #(
    parameter int unsigned P_RST_HOLD_CYC     = 256,
    parameter int unsigned P_DONE_FILTER_CYC  = 8,
    parameter int unsigned P_LOCK_TIMEOUT_CYC = 1048576
) (
    input  logic       clk_freerun_in,
    input  logic       reset_all_in,
    input  logic       reset_rx_req_in,
    input  logic       pll_lock_in,
    input  logic       rx_cdr_lock_in,
    input  logic       gt_tx_resetdone_in,
    input  logic       gt_rx_resetdone_in,
    output logic       gt_pll_reset_out,
    output logic       gt_tx_reset_out,
    output logic       gt_rx_reset_out,
    output logic       tx_init_done_out,
    output logic       rx_init_done_out,
    output logic [2:0] tx_state_out,
    output logic [2:0] rx_state_out
`ifdef GTF_RESET_CTRL_TIMEOUT_CNT_EN
    ,
    output logic [7:0] timeout_ctr_out
`endif
);

    localparam int unsigned HoldW = (P_RST_HOLD_CYC > 1) ? $clog2(P_RST_HOLD_CYC) : 1;
    localparam int unsigned TmoW  = (P_LOCK_TIMEOUT_CYC > 1) ? $clog2(P_LOCK_TIMEOUT_CYC) : 1;
    localparam int unsigned FltW  = $clog2(P_DONE_FILTER_CYC + 1);

    localparam logic [HoldW-1:0] HoldLast = HoldW'(P_RST_HOLD_CYC - 1);
    localparam logic [TmoW-1:0]  TmoLast  = TmoW'(P_LOCK_TIMEOUT_CYC - 1);
    localparam logic [FltW-1:0]  FltMax   = FltW'(P_DONE_FILTER_CYC);

    typedef enum logic [2:0] {
        TxPllRst  = 3'd0,
        TxPllWait = 3'd1,
        TxDpRst   = 3'd2,
        TxDpWait  = 3'd3,
        TxDone    = 3'd4
    } tx_state_e;

    typedef enum logic [2:0] {
        RxWaitPll = 3'd0,
        RxDpRst   = 3'd1,
        RxCdrWait = 3'd2,
        RxDpWait  = 3'd3,
        RxDone    = 3'd4
    } rx_state_e;

    tx_state_e        r_tx_state;
    tx_state_e        w_tx_next;
    rx_state_e        r_rx_state;
    rx_state_e        w_rx_next;
    logic [HoldW-1:0] r_tx_hold;
    logic [HoldW-1:0] r_rx_hold;
    logic [TmoW-1:0]  r_tx_tmo;
    logic [TmoW-1:0]  r_rx_tmo;
    logic             w_tx_tmo;
    logic             w_rx_tmo;

    logic [FltW-1:0]  r_flt [4];
    logic [3:0]       w_flt_in;
    logic [3:0]       w_acc;
    logic             w_pll_ok;
    logic             w_cdr_ok;
    logic             w_txrd_ok;
    logic             w_rxrd_ok;

    logic             r_pll_rst;
    logic             r_tx_rst;
    logic             r_rx_rst;
    logic             r_tx_done;
    logic             r_rx_done;

    // Done filters: run length of consecutive high samples, saturating at the filter depth.
    assign w_flt_in = {gt_rx_resetdone_in, gt_tx_resetdone_in, rx_cdr_lock_in, pll_lock_in};

    always_ff @(posedge clk_freerun_in) begin
        for (int i = 0; i < 4; i++) begin
            if (reset_all_in || !w_flt_in[i]) begin
                r_flt[i] <= '0;
            end else if (r_flt[i] != FltMax) begin
                r_flt[i] <= r_flt[i] + FltW'(1);
            end
        end
    end

    always_comb begin
        w_acc = '0;
        for (int i = 0; i < 4; i++) begin
            w_acc[i] = (r_flt[i] == FltMax);
        end
    end

    assign w_pll_ok  = w_acc[0];
    assign w_cdr_ok  = w_acc[1];
    assign w_txrd_ok = w_acc[2];
    assign w_rxrd_ok = w_acc[3];

    always_comb begin
        w_tx_next = r_tx_state;
        w_tx_tmo  = 1'b0;
        case (r_tx_state)
            TxPllRst: begin
                if (r_tx_hold == HoldLast) w_tx_next = TxPllWait;
            end
            TxPllWait: begin
                if (w_pll_ok) begin
                    w_tx_next = TxDpRst;
                end else if (r_tx_tmo == TmoLast) begin
                    w_tx_next = TxPllRst;
                    w_tx_tmo  = 1'b1;
                end
            end
            TxDpRst: begin
                if (r_tx_hold == HoldLast) w_tx_next = TxDpWait;
            end
            TxDpWait: begin
                if (w_txrd_ok) begin
                    w_tx_next = TxDone;
                end else if (r_tx_tmo == TmoLast) begin
                    w_tx_next = TxDpRst;
                    w_tx_tmo  = 1'b1;
                end
            end
            TxDone: begin
                if (!pll_lock_in) w_tx_next = TxPllRst;
            end
            default: w_tx_next = TxPllRst;
        endcase
    end

    always_comb begin
        w_rx_next = r_rx_state;
        w_rx_tmo  = 1'b0;
        case (r_rx_state)
            RxWaitPll: begin
                if (r_tx_state >= TxDpRst) w_rx_next = RxDpRst;
            end
            RxDpRst: begin
                if (r_rx_hold == HoldLast) w_rx_next = RxCdrWait;
            end
            RxCdrWait: begin
                if (w_cdr_ok) begin
                    w_rx_next = RxDpWait;
                end else if (r_rx_tmo == TmoLast) begin
                    w_rx_next = RxDpRst;
                    w_rx_tmo  = 1'b1;
                end
            end
            RxDpWait: begin
                if (w_rxrd_ok) begin
                    w_rx_next = RxDone;
                end else if (r_rx_tmo == TmoLast) begin
                    w_rx_next = RxDpRst;
                    w_rx_tmo  = 1'b1;
                end
            end
            RxDone: begin
                if (!rx_cdr_lock_in) w_rx_next = RxDpRst;
            end
            default: w_rx_next = RxWaitPll;
        endcase
        if (reset_rx_req_in && (r_rx_state != RxWaitPll)) begin
            w_rx_next = RxDpRst;
            w_rx_tmo  = 1'b0;
        end
        // A TX restart drags RX back to the start, overriding any RX request.
        if (w_tx_next == TxPllRst) begin
            w_rx_next = RxWaitPll;
            w_rx_tmo  = 1'b0;
        end
    end

    always_ff @(posedge clk_freerun_in) begin
        if (reset_all_in) begin
            r_tx_state <= TxPllRst;
            r_tx_hold  <= '0;
            r_tx_tmo   <= '0;
        end else begin
            r_tx_state <= w_tx_next;
            if (w_tx_next != r_tx_state) begin
                r_tx_hold <= '0;
                r_tx_tmo  <= '0;
            end else begin
                if (r_tx_state inside {TxPllRst, TxDpRst}) r_tx_hold <= r_tx_hold + HoldW'(1);
                if (r_tx_state inside {TxPllWait, TxDpWait}) r_tx_tmo <= r_tx_tmo + TmoW'(1);
            end
        end
    end

    // A pending RX request pins the hold count at zero so the reset stretches with it.
    always_ff @(posedge clk_freerun_in) begin
        if (reset_all_in) begin
            r_rx_state <= RxWaitPll;
            r_rx_hold  <= '0;
            r_rx_tmo   <= '0;
        end else begin
            r_rx_state <= w_rx_next;
            if ((w_rx_next != r_rx_state) || reset_rx_req_in) begin
                r_rx_hold <= '0;
                r_rx_tmo  <= '0;
            end else begin
                if (r_rx_state == RxDpRst) r_rx_hold <= r_rx_hold + HoldW'(1);
                if (r_rx_state inside {RxCdrWait, RxDpWait}) r_rx_tmo <= r_rx_tmo + TmoW'(1);
            end
        end
    end

    always_ff @(posedge clk_freerun_in) begin
        if (reset_all_in) begin
            r_pll_rst <= 1'b1;
            r_tx_rst  <= 1'b1;
            r_rx_rst  <= 1'b1;
            r_tx_done <= 1'b0;
            r_rx_done <= 1'b0;
        end else begin
            r_pll_rst <= (w_tx_next == TxPllRst);
            r_tx_rst  <= (w_tx_next inside {TxPllRst, TxPllWait, TxDpRst});
            r_rx_rst  <= (w_rx_next inside {RxWaitPll, RxDpRst});
            r_tx_done <= (w_tx_next == TxDone);
            r_rx_done <= (w_rx_next == RxDone);
        end
    end

    assign gt_pll_reset_out = r_pll_rst;
    assign gt_tx_reset_out  = r_tx_rst;
    assign gt_rx_reset_out  = r_rx_rst;
    assign tx_init_done_out = r_tx_done;
    assign rx_init_done_out = r_rx_done;
    assign tx_state_out     = r_tx_state;
    assign rx_state_out     = r_rx_state;

`ifdef GTF_RESET_CTRL_TIMEOUT_CNT_EN
    logic [7:0] r_tmo_ctr;
    logic [8:0] w_tmo_sum;

    assign w_tmo_sum = {1'b0, r_tmo_ctr} + 9'(w_tx_tmo) + 9'(w_rx_tmo);

    always_ff @(posedge clk_freerun_in) begin
        if (reset_all_in) begin
            r_tmo_ctr <= '0;
        end else if (w_tmo_sum > 9'd255) begin
            r_tmo_ctr <= 8'hff;
        end else begin
            r_tmo_ctr <= w_tmo_sum[7:0];
        end
    end

    assign timeout_ctr_out = r_tmo_ctr;
`else
    logic w_unused_tmo;
    assign w_unused_tmo = w_tx_tmo | w_rx_tmo;
`endif

endmodule

// File: tb/tb_gtfwizard_mac_example_reset_ctrl.sv
// Bench for gtfwizard_mac_example_reset_ctrl: vector table, directed corner sequences and a
// randomized run checked against a phase-level reference model.
module tb_gtfwizard_mac_example_reset_ctrl;

    localparam int H = 4;
    localparam int F = 2;
    localparam int T = 64;

    logic       clk;
    logic       rst, req, pll, cdr, txrd, rxrd;
    logic       pll_rst, tx_rst, rx_rst, tx_done, rx_done;
    logic [2:0] tx_st, rx_st;
`ifdef GTF_RESET_CTRL_TIMEOUT_CNT_EN
    logic [7:0] tmo_ctr;
`endif

    gtfwizard_mac_example_reset_ctrl #(
        .P_RST_HOLD_CYC     (H),
        .P_DONE_FILTER_CYC  (F),
        .P_LOCK_TIMEOUT_CYC (T)
    ) dut (
        .clk_freerun_in     (clk),
        .reset_all_in       (rst),
        .reset_rx_req_in    (req),
        .pll_lock_in        (pll),
        .rx_cdr_lock_in     (cdr),
        .gt_tx_resetdone_in (txrd),
        .gt_rx_resetdone_in (rxrd),
        .gt_pll_reset_out   (pll_rst),
        .gt_tx_reset_out    (tx_rst),
        .gt_rx_reset_out    (rx_rst),
        .tx_init_done_out   (tx_done),
        .rx_init_done_out   (rx_done),
        .tx_state_out       (tx_st),
        .rx_state_out       (rx_st)
`ifdef GTF_RESET_CTRL_TIMEOUT_CNT_EN
        ,
        .timeout_ctr_out    (tmo_ctr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_model = 1'b0;

    // Reference model: phase number, cycles spent in the phase, run length of each monitored input.
    int m_tx = 0, m_rx = 0, m_tx_age = 0, m_rx_age = 0;
    int m_run [4] = '{0, 0, 0, 0};

    // Which resets each phase holds asserted (index = phase).
    bit tx_rst_of_phase [5] = '{1, 1, 1, 0, 0};
    bit rx_rst_of_phase [5] = '{1, 1, 0, 0, 0};

    typedef struct {
        int          ncyc;
        logic [5:0]  in;   // {rst, req, pll, cdr, txrd, rxrd}
        logic [10:0] exp;  // {pll_rst, tx_rst, rx_rst, tx_done, rx_done, tx_st, rx_st}
    } vec_t;

    vec_t tbl [16];

    function automatic logic [10:0] dut_vec();
        return {pll_rst, tx_rst, rx_rst, tx_done, rx_done, tx_st, rx_st};
    endfunction

    function automatic logic [10:0] model_vec();
        return {(m_tx == 0), tx_rst_of_phase[m_tx], rx_rst_of_phase[m_rx], (m_tx == 4),
                (m_rx == 4), 3'(m_tx), 3'(m_rx)};
    endfunction

    task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_step();
        bit acc [4];
        bit in [4];
        int tx_n, rx_n;
        in = '{pll, cdr, txrd, rxrd};
        for (int i = 0; i < 4; i++) acc[i] = (m_run[i] >= F);
        if (rst) begin
            m_tx = 0; m_rx = 0; m_tx_age = 0; m_rx_age = 0;
            for (int i = 0; i < 4; i++) m_run[i] = 0;
            return;
        end
        tx_n = m_tx;
        case (m_tx)
            0: if (m_tx_age + 1 >= H) tx_n = 1;
            1: if (acc[0]) tx_n = 2; else if (m_tx_age + 1 >= T) tx_n = 0;
            2: if (m_tx_age + 1 >= H) tx_n = 3;
            3: if (acc[2]) tx_n = 4; else if (m_tx_age + 1 >= T) tx_n = 2;
            default: if (!pll) tx_n = 0;
        endcase
        rx_n = m_rx;
        if (tx_n == 0) rx_n = 0;
        else if (req && m_rx != 0) rx_n = 1;
        else begin
            case (m_rx)
                0: if (m_tx >= 2) rx_n = 1;
                1: if (m_rx_age + 1 >= H) rx_n = 2;
                2: if (acc[1]) rx_n = 3; else if (m_rx_age + 1 >= T) rx_n = 1;
                3: if (acc[3]) rx_n = 4; else if (m_rx_age + 1 >= T) rx_n = 1;
                default: if (!cdr) rx_n = 1;
            endcase
        end
        m_tx_age = (tx_n != m_tx) ? 0 : m_tx_age + 1;
        m_rx_age = ((rx_n != m_rx) || (req && rx_n == 1)) ? 0 : m_rx_age + 1;
        m_tx = tx_n;
        m_rx = rx_n;
        for (int i = 0; i < 4; i++) m_run[i] = in[i] ? ((m_run[i] < 1000) ? m_run[i] + 1 : 1000) : 0;
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        if (chk_model) check("model", dut_vec(), model_vec());
    endtask

    task automatic set_in(input logic [5:0] v);
        {rst, req, pll, cdr, txrd, rxrd} = v;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    function automatic bit cond(input int which);
        case (which)
            0: return tx_done && rx_done;
            1: return rx_st == 3'd2;
            2: return tx_st == 3'd3;
            default: return rx_done;
        endcase
    endfunction

    task automatic wait_for(input string name, input int which, input int budget);
        for (int k = 0; k < budget && !cond(which); k++) step();
        check(name, {10'd0, cond(which)}, 11'd1);
    endtask

    initial begin
        bit ok;
        set_in(6'b000000);

        // Hand-computed trace of a clean bring-up, a PLL drop and a reset.
        tbl[0]  = '{2, 6'b100000, {5'b11100, 3'd0, 3'd0}};
        tbl[1]  = '{3, 6'b000000, {5'b11100, 3'd0, 3'd0}};
        tbl[2]  = '{1, 6'b000000, {5'b01100, 3'd1, 3'd0}};
        tbl[3]  = '{1, 6'b001000, {5'b01100, 3'd1, 3'd0}};
        tbl[4]  = '{1, 6'b001000, {5'b01100, 3'd1, 3'd0}};
        tbl[5]  = '{1, 6'b001000, {5'b01100, 3'd2, 3'd0}};
        tbl[6]  = '{1, 6'b001000, {5'b01100, 3'd2, 3'd1}};
        tbl[7]  = '{2, 6'b001000, {5'b01100, 3'd2, 3'd1}};
        tbl[8]  = '{1, 6'b001000, {5'b00100, 3'd3, 3'd1}};
        tbl[9]  = '{1, 6'b001010, {5'b00000, 3'd3, 3'd2}};
        tbl[10] = '{1, 6'b001010, {5'b00000, 3'd3, 3'd2}};
        tbl[11] = '{1, 6'b001010, {5'b00010, 3'd4, 3'd2}};
        tbl[12] = '{3, 6'b001110, {5'b00010, 3'd4, 3'd3}};
        tbl[13] = '{3, 6'b001111, {5'b00011, 3'd4, 3'd4}};
        tbl[14] = '{1, 6'b000111, {5'b11100, 3'd0, 3'd0}};
        tbl[15] = '{1, 6'b100000, {5'b11100, 3'd0, 3'd0}};

        for (int i = 0; i < 16; i++) begin
            set_in(tbl[i].in);
            for (int c = 0; c < tbl[i].ncyc; c++) step();
            check($sformatf("vec%0d", i), dut_vec(), tbl[i].exp);
        end

        // PLL never locks: PLL_WAIT lasts T cycles, then the PLL reset re-pulses for H cycles.
        set_in(6'b000000);
        do_reset();
        for (int i = 1; i <= 72; i++) begin
            step();
            if (i == 3)  check("pll_hold",   {9'd0, pll_rst, tx_st == 3'd0}, 11'b11);
            if (i == 4)  check("pll_wait",   {9'd0, pll_rst, tx_st == 3'd1}, 11'b01);
            if (i == 67) check("pll_no_tmo", {9'd0, pll_rst, tx_st == 3'd1}, 11'b01);
            if (i == 68) check("pll_tmo",    {9'd0, pll_rst, tx_st == 3'd0}, 11'b11);
            if (i == 71) check("pll_repulse", {10'd0, pll_rst}, 11'd1);
            if (i == 72) check("pll_rerel",   {10'd0, pll_rst}, 11'd0);
`ifdef GTF_RESET_CTRL_TIMEOUT_CNT_EN
            if (i == 68) check("tmo_ctr1", {3'd0, tmo_ctr}, 11'd1);
`endif
        end
`ifdef GTF_RESET_CTRL_TIMEOUT_CNT_EN
        for (int i = 73; i <= 136; i++) step();
        check("tmo_ctr2", {3'd0, tmo_ctr}, 11'd2);
`endif

        // RX request held 10 cycles in RX_DONE.
        set_in(6'b000000);
        do_reset();
        set_in(6'b001111);
        wait_for("bringup_req", 0, 100);
        req = 1'b1;
        step();
        check("req_first", {8'd0, rx_done, rx_rst, tx_done}, 11'b011);
        ok = 1'b1;
        for (int i = 0; i < 9; i++) begin
            step();
            if (!rx_rst || !tx_done || rx_done) ok = 1'b0;
        end
        check("req_held", {10'd0, ok}, 11'd1);
        req = 1'b0;
        ok = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            if (!rx_rst || !tx_done) ok = 1'b0;
        end
        check("req_stretch", {10'd0, ok}, 11'd1);
        step();
        check("req_release", {8'd0, rx_rst, rx_st}, {8'd0, 1'b0, 3'd2});
        wait_for("req_recomplete", 3, 50);
        check("req_tx_kept", {10'd0, tx_done}, 11'd1);

        // PLL lock dropped for one cycle while fully up.
        pll = 1'b0;
        step();
        check("drop_all", dut_vec(), {5'b11100, 3'd0, 3'd0});
        pll = 1'b1;
        for (int i = 0; i < 3; i++) step();
        check("drop_hold", {10'd0, pll_rst}, 11'd1);
        step();
        check("drop_rel", {10'd0, pll_rst}, 11'd0);
        wait_for("drop_recomplete", 0, 100);

        // reset_all together with an RX request in RX_CDR_WAIT.
        set_in(6'b000000);
        do_reset();
        set_in(6'b001010);
        wait_for("reach_cdr_wait", 1, 100);
        rst = 1'b1;
        req = 1'b1;
        step();
        check("rst_prio", dut_vec(), {5'b11100, 3'd0, 3'd0});
        set_in(6'b000000);

        // One-cycle glitch on TX resetdone is filtered out.
        do_reset();
        pll = 1'b1;
        wait_for("reach_dp_wait", 2, 100);
        txrd = 1'b1;
        step();
        txrd = 1'b0;
        ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            if (tx_st != 3'd3 || tx_done) ok = 1'b0;
        end
        check("glitch_reject", {10'd0, ok}, 11'd1);

        // Randomized run against the reference model.
        set_in(6'b000000);
        do_reset();
        chk_model = 1'b1;
        for (int seg = 0; seg < 3; seg++) begin
            int bad_pct;
            int req_pct;
            bad_pct = (seg == 1) ? 90 : ((seg == 2) ? 5 : 2);
            req_pct = (seg == 2) ? 3 : 1;
            for (int c = 0; c < 1500; c++) begin
                pll  = (m_tx != 0) ? ($urandom_range(0, 99) >= bad_pct) : ($urandom_range(0, 3) == 0);
                cdr  = (m_rx >= 2) ? ($urandom_range(0, 99) >= bad_pct) : ($urandom_range(0, 3) == 0);
                txrd = (m_tx >= 3) ? ($urandom_range(0, 99) >= bad_pct) : ($urandom_range(0, 3) == 0);
                rxrd = (m_rx >= 3) ? ($urandom_range(0, 99) >= bad_pct) : ($urandom_range(0, 3) == 0);
                req  = ($urandom_range(0, 99) < req_pct);
                rst  = ($urandom_range(0, 999) == 0);
                step();
            end
        end
        chk_model = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
